pipeline_hazard_ctrl: RTL and testbench

//  Sequences the fetch/decode (FD) and decode/execute (DE) pipeline buffers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and codes for the pipeline hazard controller.
// Holds the FSM state encoding and the 2-bit push/pop and first-time codes.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALL_HI  = 3'd1,
    CALL_LO  = 3'd2,
    RET_HI   = 3'd3,
    RET_LO   = 3'd4,
    RET_WAIT = 3'd5
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] PUSH      = 2'b01;
  localparam logic [1:0] POP       = 2'b10;
  localparam logic [1:0] FT_HI     = 2'b01;
  localparam logic [1:0] FT_LO     = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in execute whose destination
// is read by the instruction currently in decode.
module hazard_detect #(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              use1,
  input  logic              use2,
  input  logic [REG_AW-1:0] dst,
  input  logic              mem_read,
  input  logic              reg_write,
  output logic              hazard
);

  assign hazard = mem_read & reg_write &
                  ((use1 & (src1 == dst)) | (use2 & (src2 == dst)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequences the FD/DE pipeline buffers: load-use stalls, taken-branch flushes
// and the two-step CALL/RET stack sequences, plus a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int RET_BUBBLES = 2,
  parameter int PERF_W      = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_AW-1:0] dSrc1,
  input  logic [REG_AW-1:0] dSrc2,
  input  logic              dUse1,
  input  logic              dUse2,
  input  logic              dIsCall,
  input  logic              dIsRet,
  input  logic [REG_AW-1:0] eDst,
  input  logic              eMR,
  input  logic              eRW,
  input  logic              eBranchTaken,
  output logic              pcWrite,
  output logic              fdEnable,
  output logic              fdFlush,
  output logic              deFlush,
  output logic [1:0]        firstTimeCall,
  output logic [1:0]        firstTimeRET,
  output logic [1:0]        enablePushOrPop,
  output logic              busy,
  output logic [PERF_W-1:0] stallCount
);

  localparam logic [1:0] LAST_BUBBLE = 2'(RET_BUBBLES - 1);

  state_t     state, next_state;
  logic [1:0] bubble_cnt, next_bubble;
  logic       load_use;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .src1      (dSrc1),
    .src2      (dSrc2),
    .use1      (dUse1),
    .use2      (dUse2),
    .dst       (eDst),
    .mem_read  (eMR),
    .reg_write (eRW),
    .hazard    (load_use)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      bubble_cnt <= '0;
      stallCount <= '0;
    end else begin
      state      <= next_state;
      bubble_cnt <= next_bubble;
      if (!fdEnable && (stallCount != '1))
        stallCount <= stallCount + PERF_W'(1);
    end
  end

  always_comb begin
    next_state      = state;
    next_bubble     = bubble_cnt;
    pcWrite         = 1'b1;
    fdEnable        = 1'b1;
    fdFlush         = 1'b0;
    deFlush         = 1'b0;
    firstTimeCall   = CODE_NONE;
    firstTimeRET    = CODE_NONE;
    enablePushOrPop = CODE_NONE;
    busy            = (state != IDLE);

    if (Rst) begin
      pcWrite     = 1'b0;
      fdEnable    = 1'b0;
      fdFlush     = 1'b1;
      deFlush     = 1'b1;
      busy        = 1'b0;
      next_state  = IDLE;
      next_bubble = '0;
    end else if (eBranchTaken) begin
      // A taken branch squashes whatever the younger instruction was doing.
      fdFlush     = 1'b1;
      deFlush     = 1'b1;
      next_state  = IDLE;
      next_bubble = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_use) begin
            pcWrite  = 1'b0;
            fdEnable = 1'b0;
            deFlush  = 1'b1;
          end else if (dIsCall) begin
            next_state = CALL_HI;
          end else if (dIsRet) begin
            next_state = RET_HI;
          end
        end
        CALL_HI: begin
          firstTimeCall   = FT_HI;
          enablePushOrPop = PUSH;
          pcWrite         = 1'b0;
          fdEnable        = 1'b0;
          next_state      = CALL_LO;
        end
        CALL_LO: begin
          firstTimeCall   = FT_LO;
          enablePushOrPop = PUSH;
          pcWrite         = 1'b0;
          fdEnable        = 1'b0;
          next_state      = IDLE;
        end
        RET_HI: begin
          firstTimeRET    = FT_HI;
          enablePushOrPop = POP;
          pcWrite         = 1'b0;
          fdEnable        = 1'b0;
          next_state      = RET_LO;
        end
        RET_LO: begin
          firstTimeRET    = FT_LO;
          enablePushOrPop = POP;
          pcWrite         = 1'b0;
          fdEnable        = 1'b0;
          next_state      = RET_WAIT;
          next_bubble     = '0;
        end
        RET_WAIT: begin
          // Flush until the popped return address has reached fetch.
          fdFlush = 1'b1;
          deFlush = 1'b1;
          if (bubble_cnt == LAST_BUBBLE) begin
            next_state  = IDLE;
            next_bubble = '0;
          end else begin
            next_bubble = bubble_cnt + 2'd1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (RET_BUBBLES=2, PERF_W=4 so the
// stall counter saturation is reachable).
module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [2:0] dSrc1, dSrc2, eDst;
  logic       dUse1, dUse2, dIsCall, dIsRet, eMR, eRW, eBranchTaken;
  logic       pcWrite, fdEnable, fdFlush, deFlush, busy;
  logic [1:0] firstTimeCall, firstTimeRET, enablePushOrPop;
  logic [3:0] stallCount;

  typedef struct packed {
    logic [10:0] ctrl;
    logic [3:0]  sc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl #(.REG_AW(3), .RET_BUBBLES(2), .PERF_W(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .dSrc1(dSrc1), .dSrc2(dSrc2), .dUse1(dUse1), .dUse2(dUse2),
    .dIsCall(dIsCall), .dIsRet(dIsRet),
    .eDst(eDst), .eMR(eMR), .eRW(eRW), .eBranchTaken(eBranchTaken),
    .pcWrite(pcWrite), .fdEnable(fdEnable), .fdFlush(fdFlush), .deFlush(deFlush),
    .firstTimeCall(firstTimeCall), .firstTimeRET(firstTimeRET),
    .enablePushOrPop(enablePushOrPop), .busy(busy), .stallCount(stallCount)
  );

  // Control vector: {pcWrite, fdEnable, fdFlush, deFlush, ftCall, ftRet, pushPop, busy}
  function automatic logic [10:0] mk(input logic pcw, input logic fde, input logic fdf,
                                     input logic def, input logic [1:0] ftc,
                                     input logic [1:0] ftr, input logic [1:0] epp,
                                     input logic bsy);
    return {pcw, fde, fdf, def, ftc, ftr, epp, bsy};
  endfunction

  logic [10:0] v_rst, v_idle, v_stall, v_flush, v_chi, v_clo, v_rhi, v_rlo, v_rwait;

  task automatic check_output(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic clear_inputs();
    dSrc1 = '0; dSrc2 = '0; eDst = '0;
    dUse1 = 0; dUse2 = 0; dIsCall = 0; dIsRet = 0;
    eMR = 0; eRW = 0; eBranchTaken = 0;
  endtask

  task automatic set_hazard(input logic [2:0] reg_id);
    eMR = 1; eRW = 1; eDst = reg_id; dSrc1 = reg_id; dUse1 = 1;
  endtask

  // Inputs are already set at the negedge; expected result queued, sampled
  // mid-low-phase, then advance to the next negedge.
  task automatic apply_stimulus(input string tag, input logic [10:0] ctrl,
                                input logic [3:0] sc);
    exp_t e;
    sb_q.push_back('{ctrl: ctrl, sc: sc});
    #2;
    e = sb_q.pop_front();
    check_output({tag, " ctrl"},
                 {5'b0, pcWrite, fdEnable, fdFlush, deFlush, firstTimeCall,
                  firstTimeRET, enablePushOrPop, busy}, {5'b0, e.ctrl});
    check_output({tag, " stall"}, {12'b0, stallCount}, {12'b0, e.sc});
    @(negedge Clk);
  endtask

  initial begin
    v_rst   = mk(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0);
    v_idle  = mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    v_stall = mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0);
    v_flush = mk(1, 1, 1, 1, 2'b00, 2'b00, 2'b00, 0);
    v_chi   = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 1);
    v_clo   = mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 1);
    v_rhi   = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 1);
    v_rlo   = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 1);
    v_rwait = mk(1, 1, 1, 1, 2'b00, 2'b00, 2'b00, 1);

    Rst = 1;
    clear_inputs();
    @(negedge Clk);
    apply_stimulus("reset", v_rst, 4'd0);
    Rst = 0;
    apply_stimulus("idle", v_idle, 4'd0);

    // Load-use on src1, then bubble in E clears it
    set_hazard(3'd3);
    apply_stimulus("lu_src1", v_stall, 4'd0);
    clear_inputs();
    apply_stimulus("lu_clear", v_idle, 4'd1);
    eMR = 1; eRW = 1; eDst = 3'd5; dSrc2 = 3'd5; dUse2 = 1;
    apply_stimulus("lu_src2", v_stall, 4'd1);
    clear_inputs();
    eMR = 1; eRW = 1; eDst = 3'd4; dSrc1 = 3'd3; dUse1 = 1;
    apply_stimulus("lu_nomatch", v_idle, 4'd2);
    eDst = 3'd3; dUse1 = 0;
    apply_stimulus("lu_nouse", v_idle, 4'd2);
    dUse1 = 1; eRW = 0;
    apply_stimulus("lu_nowrite", v_idle, 4'd2);
    clear_inputs();

    // CALL sequence
    dIsCall = 1;
    apply_stimulus("call_idle", v_idle, 4'd2);
    dIsCall = 0;
    apply_stimulus("call_hi", v_chi, 4'd2);
    apply_stimulus("call_lo", v_clo, 4'd3);
    apply_stimulus("call_done", v_idle, 4'd4);

    // RET sequence, hazard inputs during RET_WAIT must be ignored
    dIsRet = 1;
    apply_stimulus("ret_idle", v_idle, 4'd4);
    dIsRet = 0;
    apply_stimulus("ret_hi", v_rhi, 4'd4);
    apply_stimulus("ret_lo", v_rlo, 4'd5);
    set_hazard(3'd2);
    apply_stimulus("ret_wait1", v_rwait, 4'd6);
    clear_inputs();
    apply_stimulus("ret_wait2", v_rwait, 4'd6);
    apply_stimulus("ret_done", v_idle, 4'd6);

    // CALL+RET together -> CALL; branch during CALL_LO aborts it
    dIsCall = 1; dIsRet = 1;
    apply_stimulus("both_idle", v_idle, 4'd6);
    clear_inputs();
    apply_stimulus("both_chi", v_chi, 4'd6);
    eBranchTaken = 1;
    apply_stimulus("br_call_lo", v_rwait, 4'd7);
    eBranchTaken = 0;
    apply_stimulus("br_after", v_idle, 4'd7);

    // Branch in IDLE beats load-use and CALL
    eBranchTaken = 1; dIsCall = 1; set_hazard(3'd1);
    apply_stimulus("br_idle", v_flush, 4'd7);
    clear_inputs();
    apply_stimulus("br_idle_after", v_idle, 4'd7);

    // Reset mid RET_WAIT
    dIsRet = 1;
    apply_stimulus("r5_idle", v_idle, 4'd7);
    dIsRet = 0;
    apply_stimulus("r5_hi", v_rhi, 4'd7);
    apply_stimulus("r5_lo", v_rlo, 4'd8);
    apply_stimulus("r5_wait", v_rwait, 4'd9);
    Rst = 1;
    apply_stimulus("r5_rst", v_rst, 4'd0);
    apply_stimulus("r5_rst_hold", v_rst, 4'd0);
    Rst = 0;
    apply_stimulus("r5_rel", v_idle, 4'd0);
    apply_stimulus("r5_rel2", v_idle, 4'd0);

    // Held hazard saturates the 4-bit counter at 15
    set_hazard(3'd6);
    for (int i = 0; i < 20; i++)
      apply_stimulus($sformatf("sat%0d", i), v_stall, (i > 15) ? 4'd15 : 4'(i));
    clear_inputs();
    apply_stimulus("sat_end", v_idle, 4'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
